// File: rtl/alu_result_stage.sv
// ALU result stage: registers result/flags, maintains SR {V,N,Z,C}, and queues
// writeback results in a 2-entry skid FIFO with valid/ready on both sides.
module alu_result_stage #(
  parameter int SIZE  = 16,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] ARIT_OUT,
  input  logic            Cout_arit,
  input  logic            V,
  input  logic            BW,
  input  logic            upd_flags,
  input  logic [3:0]      dst_reg,
  input  logic            wb_en,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_data,
  output logic [3:0]      out_reg,
  input  logic            sr_we,
  input  logic [3:0]      sr_wdata,
  output logic [3:0]      SR_FLAGS
);

  logic [SIZE-1:0] mem_data [2];
  logic [3:0]      mem_reg  [2];
  logic            wr_ptr, rd_ptr;
  logic [1:0]      count, count_nxt;

  logic            accept, push, pop;
  logic [SIZE-1:0] res;
  logic            flag_c, flag_n, flag_z;

  // Byte ops: upstream zero-extends operands, so the byte carry lands in bit 8.
  always_comb begin
    res    = ARIT_OUT;
    flag_c = Cout_arit;
    flag_n = ARIT_OUT[SIZE-1];
    if (BW) begin
      res    = {{(SIZE-8){1'b0}}, ARIT_OUT[7:0]};
      flag_c = ARIT_OUT[8];
      flag_n = ARIT_OUT[7];
    end
    flag_z = (res == '0);
  end

  assign accept    = in_valid & in_ready;
  assign push      = accept & wb_en;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign count_nxt = count + {1'b0, push} - {1'b0, pop};
  assign out_data  = mem_data[rd_ptr];
  assign out_reg   = mem_reg[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      in_ready <= 1'b1;
      SR_FLAGS <= 4'd0;
      for (int i = 0; i < 2; i++) begin
        mem_data[i] <= '0;
        mem_reg[i]  <= '0;
      end
    end else begin
      count    <= count_nxt;
      // Registered from next-state count: no out_ready -> in_ready path.
      in_ready <= (count_nxt < 2'(DEPTH));
      if (push) begin
        mem_data[wr_ptr] <= res;
        mem_reg[wr_ptr]  <= dst_reg;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      if (sr_we)
        SR_FLAGS <= sr_wdata;
      else if (accept && upd_flags)
        SR_FLAGS <= {V, flag_n, flag_z, flag_c};
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_alu_result_stage;
  localparam int SIZE = 16;

  logic            clk = 0;
  logic            rst;
  logic            in_valid, in_ready;
  logic [SIZE-1:0] ARIT_OUT;
  logic            Cout_arit, V, BW, upd_flags, wb_en;
  logic [3:0]      dst_reg;
  logic            out_valid, out_ready;
  logic [SIZE-1:0] out_data;
  logic [3:0]      out_reg;
  logic            sr_we;
  logic [3:0]      sr_wdata, SR_FLAGS;

  int n_cmp = 0;
  int n_err = 0;

  alu_result_stage #(.SIZE(SIZE), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ARIT_OUT(ARIT_OUT), .Cout_arit(Cout_arit), .V(V), .BW(BW),
    .upd_flags(upd_flags), .dst_reg(dst_reg), .wb_en(wb_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_reg(out_reg), .sr_we(sr_we), .sr_wdata(sr_wdata), .SR_FLAGS(SR_FLAGS)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] arit;
    logic        cout, v, bw, upd, wb;
    logic [3:0]  dst;
    logic [3:0]  exp_flags;
    logic        exp_valid;
    logic [15:0] exp_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    in_valid = 0; out_ready = 0; ARIT_OUT = '0; Cout_arit = 0; V = 0; BW = 0;
    upd_flags = 0; dst_reg = '0; wb_en = 1; sr_we = 0; sr_wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic c, input logic v, input logic bw,
                       input logic upd, input logic wb, input logic [3:0] d);
    in_valid = 1; ARIT_OUT = a; Cout_arit = c; V = v; BW = bw;
    upd_flags = upd; wb_en = wb; dst_reg = d;
  endtask

  // Reference flags/result from the arithmetic rules: {flags[3:0], res[15:0]}
  function automatic logic [19:0] ref_calc(input logic [15:0] a, input logic c,
                                           input logic v, input logic bw);
    int r, cc, nn;
    r  = bw ? (int'(a) % 256) : int'(a);
    cc = bw ? ((int'(a) / 256) % 2) : int'(c);
    nn = bw ? ((int'(a) / 128) % 2) : (int'(a) / 32768);
    return {v, nn[0], (r == 0), cc[0], r[15:0]};
  endfunction

  vec_t vecs [7];

  initial begin
    vecs[0] = '{16'h0000, 1, 0, 0, 1, 1, 4'h1, 4'b0011, 1, 16'h0000};
    vecs[1] = '{16'h0180, 0, 1, 1, 1, 1, 4'h2, 4'b1101, 1, 16'h0080};
    vecs[2] = '{16'h8001, 0, 1, 0, 1, 1, 4'h3, 4'b1100, 1, 16'h8001};
    vecs[3] = '{16'h0100, 0, 0, 1, 1, 1, 4'h4, 4'b0011, 1, 16'h0000};
    vecs[4] = '{16'h1234, 0, 0, 0, 0, 1, 4'h5, 4'b0011, 1, 16'h1234};
    vecs[5] = '{16'h12FF, 1, 0, 1, 1, 0, 4'h6, 4'b0100, 0, 16'h0000};
    vecs[6] = '{16'hFFFF, 1, 0, 0, 1, 1, 4'hF, 4'b0101, 1, 16'hFFFF};

    idle();
    // T1: reset held two cycles
    rst = 1; tick(); tick(); rst = 0;
    chk("rst_flags", SR_FLAGS, 4'b0000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_data", out_data, 16'h0000);

    // Table: single accept, check flags/head, then pop
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].arit, vecs[i].cout, vecs[i].v, vecs[i].bw, vecs[i].upd, vecs[i].wb,
            vecs[i].dst);
      tick();
      in_valid = 0;
      chk($sformatf("vec%0d_flags", i), SR_FLAGS, vecs[i].exp_flags);
      chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
        chk($sformatf("vec%0d_reg", i), out_reg, vecs[i].dst);
      end
      out_ready = 1; tick(); out_ready = 0;
      chk($sformatf("vec%0d_drained", i), out_valid, 1'b0);
    end

    // T4: fill with out_ready low, third entry held off
    idle();
    drive(16'h0001, 0, 0, 0, 0, 1, 4'h1); tick();
    chk("t4_rdy1", in_ready, 1'b1);
    chk("t4_head1", out_data, 16'h0001);
    drive(16'h0002, 0, 0, 0, 0, 1, 4'h2); tick();
    chk("t4_full_rdy", in_ready, 1'b0);
    drive(16'h0003, 0, 0, 0, 0, 1, 4'h3); tick();
    chk("t4_held_rdy", in_ready, 1'b0);
    chk("t4_head_stable", out_data, 16'h0001);
    out_ready = 1; tick();
    chk("t4_pop1_data", out_data, 16'h0002);
    chk("t4_pop1_rdy", in_ready, 1'b1);
    tick(); in_valid = 0;
    chk("t4_pop2_data", out_data, 16'h0003);
    chk("t4_pop2_reg", out_reg, 4'h3);
    tick();
    chk("t4_empty", out_valid, 1'b0);

    // T5: count=1 with simultaneous push/pop
    idle();
    drive(16'h0009, 0, 0, 0, 0, 1, 4'h9); tick();
    for (int i = 0; i < 4; i++) begin
      drive(16'(10 + i), 0, 0, 0, 0, 1, 4'(i)); out_ready = 1; tick();
      chk($sformatf("t5_rdy%0d", i), in_ready, 1'b1);
      chk($sformatf("t5_valid%0d", i), out_valid, 1'b1);
      chk($sformatf("t5_data%0d", i), out_data, 16'(10 + i));
    end
    idle(); out_ready = 1; tick(); out_ready = 0;
    chk("t5_empty", out_valid, 1'b0);

    // T6: direct SR write wins, then reset with two entries buffered
    drive(16'h8000, 0, 0, 0, 1, 1, 4'h7); sr_we = 1; sr_wdata = 4'b1010; tick();
    sr_we = 0;
    chk("t6_sr_win", SR_FLAGS, 4'b1010);
    drive(16'h4444, 0, 0, 0, 0, 1, 4'h8); tick();
    in_valid = 0;
    chk("t6_full", in_ready, 1'b0);
    rst = 1; tick(); rst = 0;
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_rdy", in_ready, 1'b1);
    chk("t6_rst_flags", SR_FLAGS, 4'b0000);

    // Randomized traffic against a queue model
    begin
      logic [19:0] q[$];
      logic [3:0]  mflags;
      logic [19:0] r;
      logic        acc, pp;
      mflags = 4'b0000;
      idle();
      for (int cyc = 0; cyc < 400; cyc++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        ARIT_OUT  = 16'($urandom);
        if ($urandom_range(0, 7) == 0) ARIT_OUT = 16'h0000;
        Cout_arit = 1'($urandom); V = 1'($urandom); BW = 1'($urandom);
        upd_flags = 1'($urandom); wb_en = ($urandom_range(0, 4) != 0);
        dst_reg   = 4'($urandom);
        sr_we     = ($urandom_range(0, 9) == 0); sr_wdata = 4'($urandom);
        acc = in_valid && (q.size() < 2);
        pp  = out_ready && (q.size() != 0);
        r   = ref_calc(ARIT_OUT, Cout_arit, V, BW);
        tick();
        if (pp) void'(q.pop_front());
        if (acc && wb_en) q.push_back({dst_reg, r[15:0]});
        if (sr_we) mflags = sr_wdata;
        else if (acc && upd_flags) mflags = r[19:16];
        chk("rnd_flags", SR_FLAGS, mflags);
        chk("rnd_valid", out_valid, q.size() != 0);
        chk("rnd_rdy", in_ready, q.size() < 2);
        if (q.size() != 0) chk("rnd_head", {out_reg, out_data}, q[0]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
